// File: rtl/uart_msg_arbiter_pkg.sv
// Shared UART framing constants and arbiter state encodings.
// Combinational only; no latency or backpressure.
package uart_msg_arbiter_pkg;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_BIT   = 1'b1;
    localparam int   FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    // Counter width helper: never returns less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_msg_arbiter_tx8n1.sv
// 8N1 byte serializer: load starts a frame whose start bit appears the next cycle.
// 10*CLKS_PER_BIT cycles per frame; done marks the last stop-bit cycle, load then chains frames gap-free.
module uart_msg_arbiter_tx8n1
    import uart_msg_arbiter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       uart_tx,
    output logic       done
);

    localparam int                BAUD_W    = clog2_min1(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);

    logic              active_q, active_d;
    logic              tx_q, tx_d;
    logic [8:0]        shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              bit_end;

    assign bit_end = active_q && (baud_q == BAUD_LAST);
    assign done    = bit_end && (bit_cnt_q == BIT_LAST);
    assign uart_tx = tx_q;

    always_comb begin
        active_d  = active_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        if (load) begin
            active_d  = 1'b1;
            tx_d      = START_BIT;
            shift_d   = {STOP_BIT, data};
            bit_cnt_d = '0;
            baud_d    = '0;
        end else if (bit_end) begin
            baud_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
                active_d  = 1'b0;
                tx_d      = IDLE_BIT;
                bit_cnt_d = '0;
            end else begin
                // Data shifts out LSB first; the stop bit trails the byte in the shifter.
                bit_cnt_d = bit_cnt_q + 4'd1;
                tx_d      = shift_q[0];
                shift_d   = {IDLE_BIT, shift_q[8:1]};
            end
        end else if (active_q) begin
            baud_d = baud_q + BAUD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= 1'b0;
            tx_q      <= IDLE_BIT;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            baud_q    <= '0;
        end else begin
            active_q  <= active_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
        end
    end

endmodule

// File: rtl/uart_msg_arbiter.sv
// Round-robin, packet-granular sharing of one 8N1 TX line; grant one cycle after valid, start bit the next.
// Owner is stalled via req_ready until the serializer can take a byte; other requesters wait for the grant.
module uart_msg_arbiter
    import uart_msg_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 uart_tx
);

    localparam int               IDX_W    = clog2_min1(NUM_REQ);
    localparam int               GAP_CYC  = GAP_BITS * CLKS_PER_BIT;
    localparam int               GAP_W    = clog2_min1(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               last_q, last_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic             g_valid, tx_load, tx_done, pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign g_valid = req_valid[gidx_q];
    // Accept in LOAD, or on the stop bit's last cycle so packet bytes chain with no idle cycle.
    assign tx_load   = g_valid && ((state_q == LOAD) || ((state_q == SEND) && tx_done && !last_q));
    assign req_ready = grant_q & {NUM_REQ{tx_load}};
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        last_d    = last_q;
        gap_cnt_d = gap_cnt_q;
        if (tx_load) last_d = req_last[gidx_q];
        case (state_q)
            IDLE: if (pick_found) begin
                gidx_d  = pick_idx;
                grant_d = NUM_REQ'(1) << pick_idx;
                state_d = LOAD;
            end
            LOAD: if (g_valid) state_d = SEND;
            SEND: if (tx_done) begin
                if (!last_q) begin
                    state_d = g_valid ? SEND : LOAD;
                end else begin
                    grant_d   = '0;
                    rr_ptr_d  = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: if (gap_cnt_q == GAP_LAST) begin
                gap_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            last_q    <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            last_q    <= last_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    uart_msg_arbiter_tx8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .load   (tx_load),
        .data   (req_data[{gidx_q, 3'b000} +: 8]),
        .uart_tx(uart_tx),
        .done   (tx_done)
    );

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Scoreboarded bench: a line monitor decodes frames and checks byte and owner against expectations.
module tb_uart_msg_arbiter;

    localparam int NR = 2;

    typedef struct packed { logic [NR-1:0] gnt; logic [7:0] b; } exp_t;
    typedef struct packed { logic [7:0] d; logic l; } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid, req_last, req_ready, grant;
    logic [8*NR-1:0]   req_data;
    logic              busy, uart_tx;

    logic              rst4 = 1'b1;
    logic [1:0]        v4 = '0, l4 = '0, r4, g4;
    logic [15:0]       d4 = '0;
    logic              busy4, tx4;

    uart_msg_arbiter #(.NUM_REQ(NR), .CLKS_PER_BIT(1), .GAP_BITS(11)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy), .uart_tx(uart_tx));

    uart_msg_arbiter #(.NUM_REQ(2), .CLKS_PER_BIT(4), .GAP_BITS(2)) dut4 (
        .clk(clk), .reset(rst4), .req_valid(v4), .req_data(d4),
        .req_last(l4), .req_ready(r4), .grant(g4), .busy(busy4), .uart_tx(tx4));

    int tests_run = 0, tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    item_t         txq[NR][$];
    exp_t          sb[$];
    int            start_q[$];
    logic [NR-1:0] pause = '0;
    logic [NR-1:0] acc;
    int            acc_cnt[NR];

    // Requester driver: presents queue heads, pops on observed handshakes.
    initial begin
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < NR; i++) acc_cnt[i] = 0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && txq[i].size() != 0) begin
                    void'(txq[i].pop_front());
                    acc_cnt[i]++;
                end
                if (txq[i].size() != 0 && !pause[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = txq[i][0].d;
                    req_last[i]         = txq[i][0].l;
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // Line monitor for the CLKS_PER_BIT=1 instance.
    initial begin : monitor
        logic [7:0]    b;
        logic [NR-1:0] g;
        logic          ok, stp;
        int            t0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx == 1'b0) begin
                t0 = cyc; g = grant; ok = 1'b1; b = '0; stp = 1'b0;
                for (int i = 0; i < 9 && ok; i++) begin
                    @(negedge clk);
                    if (reset) ok = 1'b0;
                    else if (i < 8) b[i] = uart_tx;
                    else stp = uart_tx;
                end
                if (ok) begin
                    start_q.push_back(t0);
                    check("frame_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("frame_owner_byte", 32'({g, b}), 32'(e));
                    end
                    check("stop_bit", 32'(stp), 32'd1);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (req_ready != '0) begin
            check("ready_to_owner", 32'(req_ready & ~grant), 32'd0);
            check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin txq[i].delete(); acc_cnt[i] = 0; end
        pause = '0; sb.delete(); start_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, input int lim);
        int k = 0;
        do begin @(negedge clk); k++; end
        while ((busy || sb.size() != 0 || txq[0].size() != 0 || txq[1].size() != 0 || req_valid != '0) && k < lim);
        check(tag, 32'(k < lim), 32'd1);
    endtask

    initial begin
        int c0, ca, k;
        logic [9:0] f;
        logic expb[$];

        // Test 1: single 'H' packet, exact line pattern and gap timing.
        do_reset();
        check("reset_state", 32'({uart_tx, grant, busy, req_ready}), 32'(6'b10_0000));
        @(negedge clk);
        txq[0].push_back('{d: 8'h48, l: 1'b1});
        sb.push_back('{gnt: 2'b01, b: 8'h48});
        c0 = cyc + 1;
        wait_cyc(c0);
        check("t1_idle_cycle0", 32'({grant, busy}), 32'(3'b000));
        wait_cyc(c0 + 1);
        check("t1_grant_accept", 32'({grant, req_ready}), 32'(4'b0101));
        f = {1'b1, 8'h48, 1'b0};
        for (int i = 0; i < 10; i++) begin
            wait_cyc(c0 + 2 + i);
            check("t1_line_bit", 32'(uart_tx), 32'(f[i]));
        end
        wait_cyc(c0 + 12);
        check("t1_gap_start", 32'({uart_tx, grant, busy}), 32'(4'b1001));
        wait_cyc(c0 + 22);
        check("t1_gap_end_busy", 32'({uart_tx, busy}), 32'(2'b11));
        wait_cyc(c0 + 23);
        check("t1_idle_after_gap", 32'({uart_tx, grant, busy}), 32'(4'b1000));
        check("t1_start_cycle", 32'(start_q.size() == 1 ? start_q[0] - c0 : -1), 32'd2);

        // Test 2: both requesters continuously valid, 1-byte packets alternate.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            txq[0].push_back('{d: 8'h41, l: 1'b1});
            txq[1].push_back('{d: 8'h42, l: 1'b1});
            sb.push_back('{gnt: 2'b01, b: 8'h41});
            sb.push_back('{gnt: 2'b10, b: 8'h42});
        end
        wait_quiet("t2_complete", 400);
        check("t2_accepts_req0", 32'(acc_cnt[0]), 32'd2);
        check("t2_accepts_req1", 32'(acc_cnt[1]), 32'd2);

        // Test 3: two-byte packet chains gap-free; req1 waits for stop + gap.
        do_reset();
        @(negedge clk);
        txq[0].push_back('{d: 8'h48, l: 1'b0});
        txq[0].push_back('{d: 8'h69, l: 1'b1});
        txq[1].push_back('{d: 8'h42, l: 1'b1});
        sb.push_back('{gnt: 2'b01, b: 8'h48});
        sb.push_back('{gnt: 2'b01, b: 8'h69});
        sb.push_back('{gnt: 2'b10, b: 8'h42});
        wait_quiet("t3_complete", 300);
        check("t3_frames", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            check("t3_back_to_back", 32'(start_q[1] - start_q[0]), 32'd10);
            check("t3_req1_after_gap", 32'(start_q[2] - start_q[1]), 32'd23);
        end

        // Test 4: owner stalls mid-packet; grant held, line idle, req1 starved.
        do_reset();
        @(negedge clk);
        txq[0].push_back('{d: 8'h48, l: 1'b0});
        txq[0].push_back('{d: 8'h69, l: 1'b1});
        txq[1].push_back('{d: 8'h42, l: 1'b1});
        sb.push_back('{gnt: 2'b01, b: 8'h48});
        sb.push_back('{gnt: 2'b01, b: 8'h69});
        sb.push_back('{gnt: 2'b10, b: 8'h42});
        k = 0;
        while (acc_cnt[0] == 0 && k < 20) begin @(negedge clk); k++; end
        check("t4_first_accept", 32'(acc_cnt[0]), 32'd1);
        pause[0] = 1'b1;
        ca = cyc;
        for (int i = 10; i < 25; i++) begin
            wait_cyc(ca + i);
            check("t4_stall_hold", 32'({uart_tx, grant, req_ready}), 32'(5'b1_01_00));
        end
        pause[0] = 1'b0;
        wait_cyc(ca + 25);
        check("t4_same_cycle_accept", 32'(req_ready), 32'(2'b01));
        wait_quiet("t4_complete", 300);
        check("t4_accepts_req1", 32'(acc_cnt[1]), 32'd1);
        if (start_q.size() == 3)
            check("t4_resume_start", 32'(start_q[1] - ca), 32'd26);
        else
            check("t4_frames", 32'(start_q.size()), 32'd3);

        // Test 5: reset mid-frame aborts and clears the round-robin pointer.
        do_reset();
        @(negedge clk);
        txq[0].push_back('{d: 8'h41, l: 1'b1});
        sb.push_back('{gnt: 2'b01, b: 8'h41});
        wait_quiet("t5_first_packet", 200);
        txq[0].push_back('{d: 8'h55, l: 1'b1});
        k = 0;
        while (uart_tx != 1'b0 && k < 20) begin @(negedge clk); k++; end
        check("t5_frame_started", 32'(k < 20), 32'd1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_abort_state", 32'({uart_tx, grant, busy, req_ready}), 32'(6'b10_0000));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txq[0].push_back('{d: 8'h41, l: 1'b1});
        txq[1].push_back('{d: 8'h42, l: 1'b1});
        sb.push_back('{gnt: 2'b01, b: 8'h41});
        sb.push_back('{gnt: 2'b10, b: 8'h42});
        wait_quiet("t5_restart", 200);

        // Test 6: slow baud instance, 4 clocks per bit and an 8-cycle gap.
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        v4 = 2'b01; d4 = 16'h0055; l4 = 2'b01;
        c0 = cyc;
        f = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) repeat (4) expb.push_back(f[i]);
        repeat (8) expb.push_back(1'b1);
        wait_cyc(c0 + 1);
        check("t6_accept", 32'({g4, r4}), 32'(4'b0101));
        for (int i = 0; i < 48; i++) begin
            wait_cyc(c0 + 2 + i);
            check("t6_line_bit", 32'(tx4), 32'(expb.pop_front()));
            if (i == 0) d4 = 16'h00AA;
            if (i == 47) check("t6_gap_busy", 32'({busy4, g4}), 32'(3'b100));
        end
        wait_cyc(c0 + 50);
        check("t6_idle", 32'({busy4, g4}), 32'(3'b000));
        wait_cyc(c0 + 51);
        check("t6_next_grant", 32'({g4, r4}), 32'(4'b0101));
        v4 = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
